dmem_responder: RTL and testbench

Data-memory responder serving the MEM-stage load/store requests of the five-stage pipeline. It returns load data in the same cycle as the request, and posts stores into a small in-order store buffer that drains to a single-port word array during idle cycles. A combinational stall goes to the hazard unit when a request cannot be accepted. A sticky misalignment flag is reported for debug.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder_store_buffer.sv | 63 ++++++
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    localparam int MAX_AW           = 30;
    localparam int SB_DEPTH_DEFAULT = 4;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Word index is carried at its widest possible size; narrower arrays zero-extend.
    typedef struct packed {
        logic [MAX_AW-1:0] idx;
        logic [31:0]       data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bundle between pipeline and data memory
interface dmem_responder_if;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        req_re;
    logic [31:0] rdata;
    logic        stall_m;

    modport master (
        output req_addr, req_wdata, req_we, req_re,
        input  rdata, stall_m
    );

    modport slave (
        input  req_addr, req_wdata, req_we, req_re,
        output rdata, stall_m
    );

endinterface

// File: rtl/dmem_responder_store_buffer.sv
// rtl/dmem_responder_store_buffer.sv - in-order store FIFO with youngest-match lookup
module store_buffer
    import dmem_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              push,
    input  sb_entry_t         push_entry,
    input  logic              pop,
    output sb_entry_t         head_entry,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    input  logic [MAX_AW-1:0] lookup_idx,
    output logic              hit,
    output logic [31:0]       hit_data
);

    sb_entry_t         entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_entry;
    end

    assign head_entry = entries[head];
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);

    // Scan oldest to youngest so the last match found is the youngest one.
    always_comb begin
        logic [PW-1:0] pos;
        hit      = 1'b0;
        hit_data = '0;
        pos      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head + PW'(i);
            if ((CW'(i) < count) && (entries[pos].idx == lookup_idx)) begin
                hit      = 1'b1;
                hit_data = entries[pos].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - zero-latency data memory with store buffer; DMEM_STORE_FWD_EN enables load forwarding
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = SB_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                clr_n,
    dmem_responder_if.slave     bus,
    output logic                sb_empty,
    output logic                misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(SB_DEPTH) + 1;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          is_store;
    logic          is_load;
    logic          has_req;
    logic          stall;
    logic          accept;
    logic          push;
    logic          drain;
    logic [31:0]   rdata;

    sb_entry_t     push_entry;
    sb_entry_t     head_entry;
    logic [CW-1:0] sb_count;
    logic          sb_full;
    logic          sb_is_empty;
    logic          sb_hit;
    logic [31:0]   sb_hit_data;

    assign word_idx = bus.req_addr[AW+1:2];
    assign is_store = bus.req_we;
    assign is_load  = bus.req_re & ~bus.req_we;
    assign has_req  = is_store | is_load;

    assign push_entry.idx  = MAX_AW'(word_idx);
    assign push_entry.data = bus.req_wdata;

    store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .clr_n      (clr_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
        .count      (sb_count),
        .full       (sb_full),
        .empty      (sb_is_empty),
        .lookup_idx (MAX_AW'(word_idx)),
        .hit        (sb_hit),
        .hit_data   (sb_hit_data)
    );

    // Stall depends only on request inputs and buffer state, never on rdata.
    always_comb begin
        stall = is_store & sb_full;
`ifndef DMEM_STORE_FWD_EN
        if (is_load && sb_hit) stall = 1'b1;
`endif
    end

    assign accept = has_req & ~stall;
    assign push   = is_store & ~stall;
    // The array is single-port: drain only when no accepted request needs it.
    assign drain  = ~sb_is_empty & (~has_req | stall);

    always_ff @(posedge clk) begin
        if (drain) mem[head_entry.idx[AW-1:0]] <= head_entry.data;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)                                   misalign_err <= 1'b0;
        else if (accept && (bus.req_addr[1:0] != 2'b00)) misalign_err <= 1'b1;
    end

    always_comb begin
        rdata = '0;
        if (is_load) begin
`ifdef DMEM_STORE_FWD_EN
            rdata = sb_hit ? sb_hit_data : mem[word_idx];
`else
            rdata = mem[word_idx];
`endif
        end
    end

    assign bus.rdata   = rdata;
    assign bus.stall_m = stall;
    assign sb_empty    = sb_is_empty;

    logic unused_bits;
    assign unused_bits = ^{bus.req_addr[31:AW+2], head_entry.idx[MAX_AW-1:AW], sb_count};

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder, both DMEM_STORE_FWD_EN builds
module tb_dmem_responder;

`ifdef DMEM_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr_n;
    logic sb_empty;
    logic misalign_err;

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(1024), .SB_DEPTH(4)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .bus          (bus.slave),
        .sb_empty     (sb_empty),
        .misalign_err (misalign_err)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mdl [int];
    logic [31:0] exp_q [$];
    int          st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.req_we    = 1'b0;
        bus.req_re    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; compares load data in the accepting cycle.
    task automatic issue(input string tag, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] data, output int stalls);
        int widx;
        logic [31:0] got;
        widx          = int'(addr[11:2]);
        bus.req_we    = we;
        bus.req_re    = re;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        if (re) exp_q.push_back(we ? 32'h0 : (mdl.exists(widx) ? mdl[widx] : 32'hx));
        if (we) mdl[widx] = data;
        stalls = 0;
        @(negedge clk);
        while (bus.stall_m && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (bus.stall_m) check({tag, "_timeout"}, 32'(bus.stall_m), 32'h0);
        if (re) begin
            got = bus.rdata;
            check({tag, "_rdata"}, got, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_sb_empty", 32'(sb_empty), 32'h1);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        check("rst_stall", 32'(bus.stall_m), 32'h0);
        check("idle_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        #1 clr_n = 1'b1;
        idle(1);

        // Reset mid-operation discards the buffered store to word 5
        issue("st_w5a", 1'b1, 1'b0, 32'h15, 32'h1111_1111, st);
        idle(4);
        check("mis_after_15", 32'(misalign_err), 32'h1);
        check("drained_w5a", 32'(sb_empty), 32'h1);
        issue("st_w5b", 1'b1, 1'b0, 32'h14, 32'h2222_2222, st);
        bus.req_we = 1'b0;
        check("sb_holds_w5b", 32'(sb_empty), 32'h0);
        clr_n = 1'b0;
        #1;
        check("rst_mid_sb_empty", 32'(sb_empty), 32'h1);
        check("rst_mid_misalign", 32'(misalign_err), 32'h0);
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        @(negedge clk);
        check("rst_mid_stall", 32'(bus.stall_m), 32'h0);
        mdl[5] = 32'h1111_1111;
        @(posedge clk);
        #1;
        issue("ld_w5", 1'b0, 1'b1, 32'h14, 32'h0, st);

        // Store followed immediately by a load of the same word
        idle(2);
        issue("st_10", 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, st);
        issue("ld_10", 1'b0, 1'b1, 32'h10, 32'h0, st);
        check("ld_10_stalls", 32'(st), FWD ? 32'd0 : 32'd1);

        // Five back-to-back stores overflow a 4-entry buffer once
        idle(2);
        for (int i = 0; i < 5; i++) begin
            issue($sformatf("st_burst%0d", i), 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i), st);
            check($sformatf("st_burst%0d_stalls", i), 32'(st), (i == 4) ? 32'd1 : 32'd0);
        end
        idle(8);
        check("burst_drained", 32'(sb_empty), 32'h1);
        for (int i = 0; i < 5; i++)
            issue($sformatf("ld_burst%0d", i), 1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'h0, st);

        // Youngest buffer entry wins
        idle(2);
        issue("st_20a", 1'b1, 1'b0, 32'h20, 32'h1, st);
        issue("st_20b", 1'b1, 1'b0, 32'h20, 32'h2, st);
        issue("ld_20", 1'b0, 1'b1, 32'h20, 32'h0, st);
        check("ld_20_stalls", 32'(st), FWD ? 32'd0 : 32'd2);
        idle(4);
        issue("ld_20_arr", 1'b0, 1'b1, 32'h20, 32'h0, st);

        // Misaligned store is sticky and lands in the aliased word
        idle(2);
        issue("st_1002", 1'b1, 1'b0, 32'h1002, 32'hCAFE_0001, st);
        check("mis_set", 32'(misalign_err), 32'h1);
        idle(5);
        check("mis_sticky", 32'(misalign_err), 32'h1);
        issue("ld_0_a", 1'b0, 1'b1, 32'h0, 32'h0, st);

        // 0x1000 aliases word 0
        idle(2);
        issue("st_1000", 1'b1, 1'b0, 32'h1000, 32'hA, st);
        issue("ld_0_b", 1'b0, 1'b1, 32'h0, 32'h0, st);
        check("ld_0_b_stalls", 32'(st), FWD ? 32'd0 : 32'd1);

        // Simultaneous store+load is a store with zero read data
        idle(2);
        issue("stld_30", 1'b1, 1'b1, 32'h30, 32'h33, st);
        idle(4);
        issue("ld_30", 1'b0, 1'b1, 32'h30, 32'h0, st);
        idle(1);
        @(negedge clk);
        check("idle_rdata_end", bus.rdata, 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
